// File: rtl/ssm_pkg.sv
// Shared definitions for the packet-snapshot RAM read side: address split,
// header codes and the read controller state encoding.
package ssm_pkg;

  localparam int SLOTS      = 16;
  localparam int SLOT_WORDS = 128;
  localparam int SLOT_W     = 4;
  localparam int WORD_W     = 7;
  localparam int ADDR_W     = SLOT_W + WORD_W;
  localparam int DATA_W     = 134;
  localparam int TS_WORD    = 5;

  localparam logic [1:0] HDR_HEAD = 2'b01;
  localparam logic [1:0] HDR_MID  = 2'b11;
  localparam logic [1:0] HDR_TAIL = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WR,
    READ,
    DRAIN,
    CLEAR
  } state_t;

endpackage

// File: rtl/ssm_rd_ctrl_if.sv
// RAM read port plus the replayed output stream of the snapshot reader.
interface ssm_rd_ctrl_if;

  logic [ssm_pkg::ADDR_W-1:0] ssm_rd_addr;
  logic                       ssm_rd_en;
  logic [ssm_pkg::DATA_W-1:0] ssm_rdata;
  logic                       in_ssm_rd_alf;
  logic [ssm_pkg::DATA_W-1:0] out_ssm_rd_data;
  logic                       out_ssm_rd_data_wr;
  logic                       out_ssm_rd_valid;
  logic                       out_ssm_rd_valid_wr;

  modport master (
    output ssm_rd_addr, ssm_rd_en,
    output out_ssm_rd_data, out_ssm_rd_data_wr, out_ssm_rd_valid, out_ssm_rd_valid_wr,
    input  ssm_rdata, in_ssm_rd_alf
  );

  modport slave (
    input  ssm_rd_addr, ssm_rd_en,
    input  out_ssm_rd_data, out_ssm_rd_data_wr, out_ssm_rd_valid, out_ssm_rd_valid_wr,
    output ssm_rdata, in_ssm_rd_alf
  );

endinterface

// File: rtl/ssm_len_table.sv
// Per-slot last-word index table: one write port, one async read port,
// whole-table clear.
module ssm_len_table
  import ssm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [SLOT_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [SLOT_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [SLOTS];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < SLOTS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ssm_rd_ctrl.sv
// Snoops committed packets in the snapshot RAM, replays them in slot order
// on a host start, then asks the write engine to clear.
//
// state   | meaning
// IDLE    | snooping only, waiting for ctrl_rd_start
// WAIT_WR | start accepted mid-packet, waiting for its tail
// READ    | issuing RAM reads slot by slot
// DRAIN   | last read data still in flight
// CLEAR   | reset_wr asserted, counters and length table cleared
module ssm_rd_ctrl
  import ssm_pkg::*;
#(
  parameter int CLR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mon_wr_addr,
  input  logic [1:0]        mon_wr_hdr,
  input  logic              mon_wr_en,
  input  logic              ctrl_rd_start,
  ssm_rd_ctrl_if.master     rd,
  output logic              reset_wr,
  output logic [4:0]        pkt_num,
  output logic              busy,
  output logic              overflow
);

  localparam int CNT_W = $clog2(CLR_CYCLES + 1);

  state_t            state, state_nxt;
  logic              in_pkt;
  logic [4:0]        snap;
  logic [SLOT_W-1:0] slot;
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] len_rd;
  logic [CNT_W-1:0]  clr_cnt;
  logic              rd_q, last_q;

  logic head, tail, commit_ok, rd_go, last, slot_final, enter_read;
  logic [4:0] pkt_num_nxt;

  assign head        = mon_wr_en && (mon_wr_hdr == HDR_HEAD);
  assign tail        = mon_wr_en && (mon_wr_hdr == HDR_TAIL);
  assign commit_ok   = tail && (state != CLEAR) && (pkt_num < 5'(SLOTS));
  assign pkt_num_nxt = pkt_num + 5'(commit_ok);
  assign rd_go       = (state == READ) && !rd.in_ssm_rd_alf;
  assign last        = (word == len_rd);
  assign slot_final  = ({1'b0, slot} == snap - 5'd1);
  assign enter_read  = (state != READ) && (state_nxt == READ);

  ssm_len_table u_len (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == CLEAR),
    .we    (commit_ok),
    .waddr (mon_wr_addr[ADDR_W-1:WORD_W]),
    .wdata (mon_wr_addr[WORD_W-1:0]),
    .raddr (slot),
    .rdata (len_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ctrl_rd_start) begin
          if (in_pkt)             state_nxt = WAIT_WR;
          else if (pkt_num == '0) state_nxt = CLEAR;
          else                    state_nxt = READ;
        end
      end
      // the tail commits on this edge, so READ starts on the following cycle
      WAIT_WR: if (tail) state_nxt = READ;
      READ:    if (rd_go && last && slot_final) state_nxt = DRAIN;
      DRAIN:   state_nxt = CLEAR;
      CLEAR:   if (clr_cnt == CNT_W'(CLR_CYCLES - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd.ssm_rd_en   = 1'b0;
    rd.ssm_rd_addr = '0;
    reset_wr       = 1'b0;
    busy           = 1'b0;
    if (rd_go) begin
      rd.ssm_rd_en   = 1'b1;
      rd.ssm_rd_addr = {slot, word};
    end
    if (state == CLEAR) reset_wr = 1'b1;
    if (state != IDLE)  busy = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_pkt                 <= 1'b0;
      pkt_num                <= '0;
      overflow               <= 1'b0;
      snap                   <= '0;
      slot                   <= '0;
      word                   <= '0;
      clr_cnt                <= '0;
      rd_q                   <= 1'b0;
      last_q                 <= 1'b0;
      rd.out_ssm_rd_data     <= '0;
      rd.out_ssm_rd_data_wr  <= 1'b0;
      rd.out_ssm_rd_valid    <= 1'b0;
      rd.out_ssm_rd_valid_wr <= 1'b0;
    end else begin
      if (tail)      in_pkt <= 1'b0;
      else if (head) in_pkt <= 1'b1;

      if (state == CLEAR) begin
        pkt_num  <= '0;
        overflow <= 1'b0;
      end else if (tail) begin
        if (commit_ok) pkt_num  <= pkt_num_nxt;
        else           overflow <= 1'b1;
      end

      // snapshot includes a commit landing on the entry edge itself
      if (enter_read) begin
        snap <= pkt_num_nxt;
        slot <= '0;
        word <= '0;
      end else if (rd_go) begin
        if (last) begin
          word <= '0;
          slot <= slot + SLOT_W'(1);
        end else begin
          word <= word + WORD_W'(1);
        end
      end

      if (state == CLEAR) clr_cnt <= clr_cnt + CNT_W'(1);
      else                clr_cnt <= '0;

      rd_q                   <= rd_go;
      last_q                 <= rd_go && last;
      rd.out_ssm_rd_data_wr  <= rd_q;
      rd.out_ssm_rd_valid    <= rd_q && last_q;
      rd.out_ssm_rd_valid_wr <= rd_q && last_q;
      if (rd_q) rd.out_ssm_rd_data <= rd.ssm_rdata;
    end
  end

endmodule

// File: tb/tb_ssm_rd_ctrl.sv
// Directed bench for ssm_rd_ctrl: snoop-port packet writes, replay checks
// against a slot/length model, backpressure, mid-write start, overflow, reset.
module tb_ssm_rd_ctrl;
  import ssm_pkg::*;

  logic        clk, rst;
  logic [10:0] mon_wr_addr;
  logic [1:0]  mon_wr_hdr;
  logic        mon_wr_en, ctrl_rd_start;
  logic        reset_wr, busy, overflow;
  logic [4:0]  pkt_num;

  ssm_rd_ctrl_if bus ();

  ssm_rd_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .mon_wr_addr   (mon_wr_addr),
    .mon_wr_hdr    (mon_wr_hdr),
    .mon_wr_en     (mon_wr_en),
    .ctrl_rd_start (ctrl_rd_start),
    .rd            (bus),
    .reset_wr      (reset_wr),
    .pkt_num       (pkt_num),
    .busy          (busy),
    .overflow      (overflow)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  int len_m [16];
  int npkt_m = 0;

  logic [10:0]  addr_q [$];
  logic [133:0] data_q [$];
  bit           vwr_q [$];
  bit           vld_q [$];
  int rwr_cnt, busy_cnt, first_rd_cyc, vwr_total;
  bit tog_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [133:0] ram_word(input logic [10:0] a);
    return {2'b10, 121'(a) * 121'd977, a};
  endfunction

  always @(posedge clk)
    if (bus.ssm_rd_en === 1'b1) bus.ssm_rdata <= ram_word(bus.ssm_rd_addr);

  always @(posedge clk) begin
    #1;
    bus.in_ssm_rd_alf = tog_en ? ~bus.in_ssm_rd_alf : 1'b0;
  end

  always @(negedge clk) begin
    if (bus.ssm_rd_en === 1'b1) begin
      addr_q.push_back(bus.ssm_rd_addr);
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (bus.out_ssm_rd_data_wr === 1'b1) begin
      data_q.push_back(bus.out_ssm_rd_data);
      vwr_q.push_back(bus.out_ssm_rd_valid_wr);
      vld_q.push_back(bus.out_ssm_rd_valid);
    end
    if (bus.out_ssm_rd_valid_wr === 1'b1) vwr_total++;
    if (reset_wr === 1'b1) rwr_cnt++;
    if (busy === 1'b1) busy_cnt++;
  end

  task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    addr_q.delete(); data_q.delete(); vwr_q.delete(); vld_q.delete();
    rwr_cnt = 0; busy_cnt = 0; vwr_total = 0; first_rd_cyc = -1;
  endtask

  task automatic snoop_word(input logic [10:0] a, input logic [1:0] h);
    @(posedge clk); #1;
    mon_wr_en = 1'b1; mon_wr_addr = a; mon_wr_hdr = h;
  endtask

  task automatic snoop_idle();
    @(posedge clk); #1;
    mon_wr_en = 1'b0;
  endtask

  task automatic write_pkt(input int slot, input int n);
    for (int w = 0; w < n; w++)
      snoop_word(11'(slot * 128 + w), (w == 0) ? HDR_HEAD : ((w == n - 1) ? HDR_TAIL : HDR_MID));
    snoop_idle();
    if (npkt_m < 16) begin
      len_m[slot] = n - 1;
      npkt_m++;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1; ctrl_rd_start = 1'b1;
    @(posedge clk); #1; ctrl_rd_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " done"}, 134'(busy), 134'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int s = 0; s < 16; s++) len_m[s] = 0;
    npkt_m = 0;
  endtask

  task automatic check_stream(input string tag);
    logic [10:0] ea [$];
    bit          el [$];
    for (int s = 0; s < npkt_m; s++)
      for (int w = 0; w <= len_m[s]; w++) begin
        ea.push_back({4'(s), 7'(w)});
        el.push_back(w == len_m[s]);
      end
    check({tag, " rd count"}, 134'(addr_q.size()), 134'(ea.size()));
    check({tag, " wr count"}, 134'(data_q.size()), 134'(ea.size()));
    for (int i = 0; i < ea.size() && i < addr_q.size(); i++)
      check($sformatf("%s addr[%0d]", tag, i), 134'(addr_q[i]), 134'(ea[i]));
    for (int i = 0; i < ea.size() && i < data_q.size(); i++) begin
      check($sformatf("%s data[%0d]", tag, i), data_q[i], ram_word(ea[i]));
      check($sformatf("%s vwr[%0d]", tag, i), 134'(vwr_q[i]), 134'(el[i]));
      check($sformatf("%s vld[%0d]", tag, i), 134'(vld_q[i]), 134'(el[i]));
    end
    check({tag, " reset_wr cycles"}, 134'(rwr_cnt), 134'(2));
    check({tag, " pkt_num after"}, 134'(pkt_num), 134'(0));
    check({tag, " overflow after"}, 134'(overflow), 134'(0));
    model_clear();
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; mon_wr_en = 1'b0; mon_wr_addr = '0; mon_wr_hdr = '0; ctrl_rd_start = 1'b0;
    model_clear();
    clear_mon();
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    check("reset rd_en", 134'(bus.ssm_rd_en), 134'(0));
    check("reset data_wr", 134'(bus.out_ssm_rd_data_wr), 134'(0));
    check("reset reset_wr", 134'(reset_wr), 134'(0));
    check("reset pkt_num", 134'(pkt_num), 134'(0));
    check("reset busy", 134'(busy), 134'(0));
    check("reset overflow", 134'(overflow), 134'(0));

    // three packets: 3, 6, 128 words
    write_pkt(0, 3); write_pkt(1, 6); write_pkt(2, 128);
    check("basic pkt_num", 134'(pkt_num), 134'(3));
    clear_mon();
    pulse_start();
    wait_idle("basic");
    check("basic 137 words", 134'(data_q.size()), 134'(137));
    check("basic vwr@3", 134'(vwr_q[2]), 134'(1));
    check("basic vwr@9", 134'(vwr_q[8]), 134'(1));
    check("basic vwr@137", 134'(vwr_q[136]), 134'(1));
    check("basic vwr total", 134'(vwr_total), 134'(3));
    check_stream("basic");

    // same packets under toggling almost-full
    write_pkt(0, 3); write_pkt(1, 6); write_pkt(2, 128);
    clear_mon();
    tog_en = 1'b1;
    pulse_start();
    wait_idle("bp");
    tog_en = 1'b0;
    check("bp 137 words", 134'(data_q.size()), 134'(137));
    check_stream("bp");

    // start between head and tail
    write_pkt(0, 2);
    snoop_word(11'd128, HDR_HEAD);
    snoop_word(11'd129, HDR_MID);
    snoop_idle();
    clear_mon();
    pulse_start();
    check("mid busy", 134'(busy), 134'(1));
    repeat (3) @(posedge clk);
    #1;
    check("mid no read", 134'(addr_q.size()), 134'(0));
    snoop_word(11'd130, HDR_MID);
    snoop_word(11'd131, HDR_TAIL);
    begin
      int tail_cyc;
      tail_cyc = cyc;
      snoop_idle();
      len_m[1] = 3; npkt_m = 2;
      wait_idle("mid");
      check("mid first read cycle", 134'(first_rd_cyc), 134'(tail_cyc + 1));
    end
    check_stream("mid");

    // 17 commits: the last is ignored and flags overflow
    for (int s = 0; s < 16; s++) write_pkt(s, 2 + s % 3);
    write_pkt(0, 5);
    check("ovf pkt_num", 134'(pkt_num), 134'(16));
    check("ovf flag", 134'(overflow), 134'(1));
    clear_mon();
    pulse_start();
    wait_idle("ovf");
    check("ovf words", 134'(data_q.size()), 134'(47));
    check_stream("ovf");

    // empty start
    clear_mon();
    pulse_start();
    wait_idle("empty");
    check("empty reads", 134'(addr_q.size()), 134'(0));
    check("empty reset_wr", 134'(rwr_cnt), 134'(2));
    check("empty busy", 134'(busy_cnt), 134'(2));

    // reset in the middle of a replay
    write_pkt(0, 128);
    pulse_start();
    repeat (10) @(posedge clk);
    #1;
    check("rst in read", 134'(bus.ssm_rd_en), 134'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst rd_en", 134'(bus.ssm_rd_en), 134'(0));
    check("rst rd_addr", 134'(bus.ssm_rd_addr), 134'(0));
    check("rst data", bus.out_ssm_rd_data, 134'(0));
    check("rst data_wr", 134'(bus.out_ssm_rd_data_wr), 134'(0));
    check("rst valid", 134'(bus.out_ssm_rd_valid), 134'(0));
    check("rst valid_wr", 134'(bus.out_ssm_rd_valid_wr), 134'(0));
    check("rst reset_wr", 134'(reset_wr), 134'(0));
    check("rst pkt_num", 134'(pkt_num), 134'(0));
    check("rst busy", 134'(busy), 134'(0));
    rst = 1'b0;
    model_clear();
    clear_mon();
    repeat (6) @(posedge clk);
    #1;
    check("rst no trailing words", 134'(data_q.size()), 134'(0));
    check("rst no trailing vwr", 134'(vwr_total), 134'(0));
    clear_mon();
    pulse_start();
    wait_idle("post-rst");
    check("post-rst reads", 134'(addr_q.size()), 134'(0));
    check("post-rst reset_wr", 134'(rwr_cnt), 134'(2));
    check("post-rst busy", 134'(busy_cnt), 134'(2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
